// File: rtl/glyph_pixel_gen.sv
// glyph_pixel_gen: 5x7 font renderer for 8x10 text cells; optional blinking cursor underline via GLYPH_CURSOR_EN
module glyph_pixel_gen #(
    parameter int          CHAR_LAT = 2,
    parameter logic [5:0]  FG_COLOR = 6'b111111,
    parameter logic [5:0]  BG_COLOR = 6'b000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] xcoor,
    input  logic [8:0] ycoor,
    input  logic       de_in,
    input  logic [5:0] char_code,
`ifdef GLYPH_CURSOR_EN
    input  logic [6:0] cursor_col,
    input  logic       cursor_row_hit,
`endif
    output logic [5:0] rgb,
    output logic       de_out
);
    function automatic logic [4:0] font_row(input logic [5:0] code, input logic [3:0] row);
        logic [34:0] g;
        g = '0;
        case (code)
            6'd0:  g = 35'b01110_10001_10011_10101_11001_10001_01110;
            6'd1:  g = 35'b00100_01100_00100_00100_00100_00100_01110;
            6'd2:  g = 35'b01110_10001_00001_00010_00100_01000_11111;
            6'd3:  g = 35'b11111_00010_00100_00010_00001_10001_01110;
            6'd4:  g = 35'b00010_00110_01010_10010_11111_00010_00010;
            6'd5:  g = 35'b11111_10000_11110_00001_00001_10001_01110;
            6'd6:  g = 35'b00110_01000_10000_11110_10001_10001_01110;
            6'd7:  g = 35'b11111_00001_00010_00100_01000_01000_01000;
            6'd8:  g = 35'b01110_10001_10001_01110_10001_10001_01110;
            6'd9:  g = 35'b01110_10001_10001_01111_00001_00010_01100;
            6'd10: g = 35'b01110_10001_10001_11111_10001_10001_10001;
            6'd11: g = 35'b11110_10001_10001_11110_10001_10001_11110;
            6'd12: g = 35'b01110_10001_10000_10000_10000_10001_01110;
            6'd13: g = 35'b11100_10010_10001_10001_10001_10010_11100;
            6'd14: g = 35'b11111_10000_10000_11110_10000_10000_11111;
            6'd15: g = 35'b11111_10000_10000_11110_10000_10000_10000;
            6'd16: g = 35'b01110_10001_10000_10111_10001_10001_01111;
            6'd17: g = 35'b10001_10001_10001_11111_10001_10001_10001;
            6'd18: g = 35'b01110_00100_00100_00100_00100_00100_01110;
            6'd19: g = 35'b00111_00010_00010_00010_00010_10010_01100;
            6'd20: g = 35'b10001_10010_10100_11000_10100_10010_10001;
            6'd21: g = 35'b10000_10000_10000_10000_10000_10000_11111;
            6'd22: g = 35'b10001_11011_10101_10101_10001_10001_10001;
            6'd23: g = 35'b10001_10001_11001_10101_10011_10001_10001;
            6'd24: g = 35'b01110_10001_10001_10001_10001_10001_01110;
            6'd25: g = 35'b11110_10001_10001_11110_10000_10000_10000;
            6'd26: g = 35'b01110_10001_10001_10001_10101_10010_01101;
            6'd27: g = 35'b11110_10001_10001_11110_10100_10010_10001;
            6'd28: g = 35'b01111_10000_10000_01110_00001_00001_11110;
            6'd29: g = 35'b11111_00100_00100_00100_00100_00100_00100;
            6'd30: g = 35'b10001_10001_10001_10001_10001_10001_01110;
            6'd31: g = 35'b10001_10001_10001_10001_10001_01010_00100;
            6'd32: g = 35'b10001_10001_10001_10101_10101_10101_01010;
            6'd33: g = 35'b10001_10001_01010_00100_01010_10001_10001;
            6'd34: g = 35'b10001_10001_10001_01010_00100_00100_00100;
            6'd35: g = 35'b11111_00001_00010_00100_01000_10000_11111;
            default: g = '0;
        endcase
        case (row)
            4'd1:    font_row = g[34:30];
            4'd2:    font_row = g[29:25];
            4'd3:    font_row = g[24:20];
            4'd4:    font_row = g[19:15];
            4'd5:    font_row = g[14:10];
            4'd6:    font_row = g[9:5];
            4'd7:    font_row = g[4:0];
            default: font_row = 5'd0;
        endcase
    endfunction

    logic [8:0]                prev_y_q, prev_y_d;
    logic [3:0]                row_q, row_d;
    logic [CHAR_LAT-1:0][2:0]  col_dly_q, col_dly_d;
    logic [CHAR_LAT-1:0]       de_dly_q, de_dly_d;
    logic [CHAR_LAT-1:0][3:0]  row_dly_q, row_dly_d;
    logic [4:0]                fbits_q, fbits_d;
    logic [2:0]                s1_col_q, s1_col_d;
    logic                      s1_de_q, s1_de_d;
    logic [5:0]                rgb_q, rgb_d;
    logic                      de_out_q, de_out_d;
    logic [7:0]                line_bits;
    logic                      lit;
`ifdef GLYPH_CURSOR_EN
    logic [CHAR_LAT-1:0][6:0]  cell_dly_q, cell_dly_d;
    logic [4:0]                frame_q, frame_d;
    logic                      s1_cur_q, s1_cur_d;
`endif

    always_comb begin
        prev_y_d = ycoor;
        row_d = (ycoor != prev_y_q) ? ((ycoor == 9'd0 || row_q == 4'd9) ? 4'd0 : row_q + 4'd1) : row_q;
        col_dly_d = '0;
        de_dly_d = '0;
        row_dly_d = '0;
        col_dly_d[0] = xcoor[2:0];
        de_dly_d[0] = de_in;
        row_dly_d[0] = row_q;
        for (int i = 1; i < CHAR_LAT; i++) begin
            col_dly_d[i] = col_dly_q[i-1];
            de_dly_d[i] = de_dly_q[i-1];
            row_dly_d[i] = row_dly_q[i-1];
        end
        fbits_d = font_row(char_code, row_dly_q[CHAR_LAT-1]);
        s1_col_d = col_dly_q[CHAR_LAT-1];
        s1_de_d = de_dly_q[CHAR_LAT-1];
        // glyph sits in cell columns 1..5, so pad one blank column left and two right
        line_bits = {1'b0, fbits_q, 2'b00};
        lit = line_bits[3'd7 - s1_col_q];
`ifdef GLYPH_CURSOR_EN
        cell_dly_d = '0;
        cell_dly_d[0] = xcoor[9:3];
        for (int i = 1; i < CHAR_LAT; i++)
            cell_dly_d[i] = cell_dly_q[i-1];
        frame_d = (ycoor != prev_y_q && ycoor == 9'd0) ? frame_q + 5'd1 : frame_q;
        s1_cur_d = cursor_row_hit && !frame_q[4] && cell_dly_q[CHAR_LAT-1] == cursor_col
                   && row_dly_q[CHAR_LAT-1] == 4'd9;
        lit = lit || s1_cur_q;
`endif
        rgb_d = s1_de_q ? (lit ? FG_COLOR : BG_COLOR) : 6'd0;
        de_out_d = s1_de_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_y_q <= '0;
            row_q <= '0;
            col_dly_q <= '0;
            de_dly_q <= '0;
            row_dly_q <= '0;
            fbits_q <= '0;
            s1_col_q <= '0;
            s1_de_q <= 1'b0;
            rgb_q <= '0;
            de_out_q <= 1'b0;
`ifdef GLYPH_CURSOR_EN
            cell_dly_q <= '0;
            frame_q <= '0;
            s1_cur_q <= 1'b0;
`endif
        end else begin
            prev_y_q <= prev_y_d;
            row_q <= row_d;
            col_dly_q <= col_dly_d;
            de_dly_q <= de_dly_d;
            row_dly_q <= row_dly_d;
            fbits_q <= fbits_d;
            s1_col_q <= s1_col_d;
            s1_de_q <= s1_de_d;
            rgb_q <= rgb_d;
            de_out_q <= de_out_d;
`ifdef GLYPH_CURSOR_EN
            cell_dly_q <= cell_dly_d;
            frame_q <= frame_d;
            s1_cur_q <= s1_cur_d;
`endif
        end
    end

    assign rgb = rgb_q;
    assign de_out = de_out_q;
endmodule
